fpu_ss_mem_meta_buffer: RTL and testbench
=========================================

Name: fpu_ss_mem_meta_buffer

Overview:
- FIFO that holds the metadata of in-flight FP load/store memory requests. It sits directly downstream of the subsystem controller's memory request path.
- An entry is pushed on each accepted memory request handshake. The head entry is popped when the matching memory result returns.
- The controller reads the head entry combinationally. It uses the entry's register-file write enable and destination register for writeback and for load-result forwarding.
- Memory results return in order, so a plain FIFO ordering is sufficient.

Parameters:
- DEPTH, 4, number of metadata entries; legal range 1..16, need not be a power of two.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter (derived, not overridable).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of all entries
- push_valid_i  in  1  new memory request accepted by the memory interface
- push_ready_o  out  1  buffer can accept an entry
- push_rd_i  in  5  destination FP register of the request
- push_we_i  in  1  request writes the FP register file (load)
- push_id_i  in  4  offload instruction id
- pop_ready_i  in  1  memory result consumed this cycle
- pop_valid_o  out  1  head entry valid
- pop_rd_o  out  5  head destination register
- pop_we_o  out  1  head write enable
- pop_id_o  out  4  head instruction id
- usage_o  out  CNT_W  number of stored entries
- empty_o  out  1  usage_o == 0
- full_o  out  1  usage_o == DEPTH
- underflow_o  out  1  sticky error: pop requested while empty

Behaviour:
- **Reset (async, rst_ni low):**
  - wr_ptr, rd_ptr, usage and underflow are cleared to 0.
  - Outputs after reset: pop_valid_o=0, push_ready_o=1, empty_o=1, full_o=0, usage_o=0, underflow_o=0.
  - Entry storage is not reset.
  - pop_rd_o, pop_we_o and pop_id_o are forced to 0 while pop_valid_o=0.
- **Push:**
  - Fires when push_valid_i & push_ready_o.
  - Writes {rd, we, id} at wr_ptr.
  - wr_ptr increments; it wraps from DEPTH-1 to 0.
- **push_ready_o:**
  - Equals ~full_o and depends only on registered state.
  - There is no combinational path from pop_ready_i.
  - A push while full_o=1 is ignored: no write, no state change.
- **Pop:**
  - Fires when pop_ready_i & pop_valid_o.
  - rd_ptr increments with the same wrap rule as wr_ptr.
  - pop_valid_o = ~empty_o.
- **No fall-through:**
  - An entry pushed in cycle N is visible at pop_* from cycle N+1 onward.
  - Latency from push to pop_valid_o is 1 cycle.
- **Simultaneous push and pop:**
  - Both fire; usage is unchanged.
  - This is legal whenever the buffer is neither empty (pop) nor full (push).
- **Counter update:** usage_d = usage_q + push_fire - pop_fire; it never exceeds DEPTH and never goes below 0.
- **Underflow:**
  - pop_ready_i=1 while empty_o=1 sets underflow_o=1.
  - underflow_o holds until reset or flush_i.
  - Pointers do not move on an underflow.
- **Flush:**
  - flush_i=1 clears pointers, usage and underflow at the next edge.
  - Flush has priority over a same-cycle push or pop; both are dropped.
- **Reset mid-operation:** all entries are lost. The next cycle presents the empty state.
- **DEPTH=1:** behaves as a single register with valid flag. push_ready_o=0 while the entry is held, so there is no push-and-pop in the same cycle when full.

Test Plan:
1. Reset, then push {rd=5, we=1, id=3}.
   - Next cycle: pop_valid_o=1, pop_rd_o=5, pop_we_o=1, pop_id_o=3, usage_o=1, empty_o=0.
   - Pop it: empty_o=1 and pop_* all 0 the following cycle.
2. DEPTH=4: push rd=1,2,3,4 on consecutive cycles.
   - full_o=1 and push_ready_o=0 after the 4th push.
   - A 5th push of rd=9 is ignored.
   - Pop 4 times: rd order 1,2,3,4 observed, then empty_o=1.
3. Hold one entry, then push rd=7 and pop in the same cycle for 10 cycles, incrementing rd each time.
   - usage_o stays 1; pop order matches push order.
   - Pointers wrap twice with no corruption.
4. Empty buffer, pop_ready_i=1 for one cycle.
   - underflow_o=1 from the next cycle and sticky; usage_o stays 0.
   - flush_i=1 clears underflow_o to 0.
5. Fill 3 entries, then assert flush_i together with push_valid_i=1 and pop_ready_i=1.
   - Next cycle: usage_o=0, empty_o=1, pop_valid_o=0, and no entry written.
6. With 2 entries held, drive rst_ni low asynchronously mid-cycle.
   - Outputs immediately go to reset values (empty_o=1, push_ready_o=1).
   - After release, a push of rd=12 pops as rd=12.

Source files
------------

// File: rtl/fpu_ss_mem_meta_buffer.sv
// Metadata FIFO for in-flight FP load/store memory requests.
// One entry {rd, we, id} is pushed per accepted memory request and the head
// entry is popped when the in-order memory result returns. The head is read
// combinationally for writeback and load-result forwarding. No fall-through:
// a pushed entry becomes visible one cycle later.
module fpu_ss_mem_meta_buffer #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [4:0]       push_rd_i,
    input  logic             push_we_i,
    input  logic [3:0]       push_id_i,
    input  logic             pop_ready_i,
    output logic             pop_valid_o,
    output logic [4:0]       pop_rd_o,
    output logic             pop_we_o,
    output logic [3:0]       pop_id_o,
    output logic [CNT_W-1:0] usage_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             underflow_o
);

    // A single-entry buffer still needs a one-bit pointer to index storage.
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic [3:0] id;
    } meta_t;

    meta_t            mem_q [DEPTH];
    meta_t            head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] usage_q, usage_d;
    logic             underflow_q, underflow_d;
    logic             empty, full;
    logic             push_fire, pop_fire;

    // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Status is derived from the registered count only, so push_ready_o has
    // no combinational path from pop_ready_i.
    assign empty     = (usage_q == '0);
    assign full      = (usage_q == CNT_W'(DEPTH));
    assign push_fire = push_valid_i & ~full;
    assign pop_fire  = pop_ready_i & ~empty;

    // Next-state logic for pointers, occupancy and the sticky underflow flag.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        usage_d     = usage_q;
        underflow_d = underflow_q;
        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            usage_d     = '0;
            underflow_d = 1'b0;
        end else begin
            if (push_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_fire)  rd_ptr_d = ptr_inc(rd_ptr_q);
            usage_d = usage_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
            if (pop_ready_i && empty) underflow_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            usage_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            usage_q     <= usage_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage; a flush drops a same-cycle push so nothing is written.
    // NOTE: storage has no reset; the count and output masking guarantee that
    // stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (push_fire && !flush_i) begin
            mem_q[wr_ptr_q] <= meta_t'{rd: push_rd_i, we: push_we_i, id: push_id_i};
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign push_ready_o = ~full;
    assign pop_valid_o  = ~empty;
    assign pop_rd_o     = pop_valid_o ? head.rd : '0;
    assign pop_we_o     = pop_valid_o ? head.we : 1'b0;
    assign pop_id_o     = pop_valid_o ? head.id : '0;
    assign usage_o      = usage_q;
    assign empty_o      = empty;
    assign full_o       = full;
    assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_fpu_ss_mem_meta_buffer.sv
// Self-checking bench for fpu_ss_mem_meta_buffer (DEPTH=4): a constant
// vector table, hand-written corner sequences and a randomized run, all
// compared against a queue-based reference model.
module tb_fpu_ss_mem_meta_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             push_valid_i;
    logic             push_ready_o;
    logic [4:0]       push_rd_i;
    logic             push_we_i;
    logic [3:0]       push_id_i;
    logic             pop_ready_i;
    logic             pop_valid_o;
    logic [4:0]       pop_rd_o;
    logic             pop_we_o;
    logic [3:0]       pop_id_o;
    logic [CNT_W-1:0] usage_o;
    logic             empty_o;
    logic             full_o;
    logic             underflow_o;

    fpu_ss_mem_meta_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .push_rd_i    (push_rd_i),
        .push_we_i    (push_we_i),
        .push_id_i    (push_id_i),
        .pop_ready_i  (pop_ready_i),
        .pop_valid_o  (pop_valid_o),
        .pop_rd_o     (pop_rd_o),
        .pop_we_o     (pop_we_o),
        .pop_id_o     (pop_id_o),
        .usage_o      (usage_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .underflow_o  (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of {rd, we, id} plus the sticky error flag.
    logic [9:0] model_q [$];
    bit         model_uf;

    typedef struct {
        bit       pv;
        bit [4:0] rd;
        bit       we;
        bit [3:0] id;
        bit       pr;
        bit       fl;
        bit       e_valid;
        bit [4:0] e_rd;
        bit       e_we;
        bit [3:0] e_id;
        int       e_usage;
        bit       e_full;
        bit       e_empty;
        bit       e_ready;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare every DUT output against the reference model.
    task automatic check_model(input string tag);
        logic [9:0] hd;
        bit         v;
        v  = (model_q.size() != 0);
        hd = v ? model_q[0] : 10'd0;
        check({tag, ".valid"},     32'(pop_valid_o),  32'(v));
        check({tag, ".rd"},        32'(pop_rd_o),     32'(hd[9:5]));
        check({tag, ".we"},        32'(pop_we_o),     32'(hd[4]));
        check({tag, ".id"},        32'(pop_id_o),     32'(hd[3:0]));
        check({tag, ".usage"},     32'(usage_o),      32'(model_q.size()));
        check({tag, ".empty"},     32'(empty_o),      32'(model_q.size() == 0));
        check({tag, ".full"},      32'(full_o),       32'(model_q.size() == DEPTH));
        check({tag, ".ready"},     32'(push_ready_o), 32'(model_q.size() != DEPTH));
        check({tag, ".underflow"}, 32'(underflow_o),  32'(model_uf));
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic cycle(input bit pv, input bit [4:0] rd, input bit we, input bit [3:0] id,
                         input bit pr, input bit fl, input string tag);
        bit push_ok, pop_ok;
        push_valid_i = pv; push_rd_i = rd; push_we_i = we; push_id_i = id;
        pop_ready_i  = pr; flush_i = fl;
        if (fl) begin
            model_q.delete();
            model_uf = 0;
        end else begin
            push_ok = pv && (model_q.size() < DEPTH);
            pop_ok  = pr && (model_q.size() > 0);
            if (pr && model_q.size() == 0) model_uf = 1;
            if (pop_ok)  void'(model_q.pop_front());
            if (push_ok) model_q.push_back({rd, we, id});
        end
        @(posedge clk_i);
        #1;
        push_valid_i = 0; pop_ready_i = 0; flush_i = 0;
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        cycle(0, 5'd0, 0, 4'd0, 0, 0, tag);
    endtask

    initial begin
        rst_ni = 0; flush_i = 0; push_valid_i = 0; pop_ready_i = 0;
        push_rd_i = '0; push_we_i = 0; push_id_i = '0;
        model_uf = 0;

        //        pv rd we id pr fl | valid rd we id usage full empty ready
        vecs[0]  = '{1, 5, 1, 3, 0, 0,  1, 5, 1, 3, 1, 0, 0, 1};
        vecs[1]  = '{0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1};
        vecs[2]  = '{1, 1, 0, 1, 0, 0,  1, 1, 0, 1, 1, 0, 0, 1};
        vecs[3]  = '{1, 2, 0, 2, 0, 0,  1, 1, 0, 1, 2, 0, 0, 1};
        vecs[4]  = '{1, 3, 0, 3, 0, 0,  1, 1, 0, 1, 3, 0, 0, 1};
        vecs[5]  = '{1, 4, 0, 4, 0, 0,  1, 1, 0, 1, 4, 1, 0, 0};
        vecs[6]  = '{1, 9, 1, 9, 0, 0,  1, 1, 0, 1, 4, 1, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 1, 0,  1, 2, 0, 2, 3, 0, 0, 1};
        vecs[8]  = '{0, 0, 0, 0, 1, 0,  1, 3, 0, 3, 2, 0, 0, 1};
        vecs[9]  = '{0, 0, 0, 0, 1, 0,  1, 4, 0, 4, 1, 0, 0, 1};
        vecs[10] = '{0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1};

        #12;
        check("rst.valid", 32'(pop_valid_o),  32'd0);
        check("rst.ready", 32'(push_ready_o), 32'd1);
        check("rst.empty", 32'(empty_o),      32'd1);
        check("rst.usage", 32'(usage_o),      32'd0);
        rst_ni = 1;
        @(posedge clk_i); #1;
        check_model("rst");

        // Single entry round trip, fill to full, ignored push, in-order drain.
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].pv, vecs[i].rd, vecs[i].we, vecs[i].id, vecs[i].pr, vecs[i].fl, "vec");
            check($sformatf("vec%0d.valid", i), 32'(pop_valid_o),  32'(vecs[i].e_valid));
            check($sformatf("vec%0d.rd", i),    32'(pop_rd_o),     32'(vecs[i].e_rd));
            check($sformatf("vec%0d.we", i),    32'(pop_we_o),     32'(vecs[i].e_we));
            check($sformatf("vec%0d.id", i),    32'(pop_id_o),     32'(vecs[i].e_id));
            check($sformatf("vec%0d.usage", i), 32'(usage_o),      32'(vecs[i].e_usage));
            check($sformatf("vec%0d.full", i),  32'(full_o),       32'(vecs[i].e_full));
            check($sformatf("vec%0d.empty", i), 32'(empty_o),      32'(vecs[i].e_empty));
            check($sformatf("vec%0d.ready", i), 32'(push_ready_o), 32'(vecs[i].e_ready));
        end

        // Steady push+pop with one entry held; pointers wrap more than twice.
        cycle(1, 5'd6, 1, 4'd6, 0, 0, "hold");
        for (int i = 0; i < 10; i++) begin
            cycle(1, 5'(7 + i), 1, 4'(i), 1, 0, "pp");
            check($sformatf("pp%0d.usage", i), 32'(usage_o),  32'd1);
            check($sformatf("pp%0d.rd", i),    32'(pop_rd_o), 32'(7 + i));
        end
        cycle(0, 5'd0, 0, 4'd0, 1, 0, "pp.drain");

        // Underflow: sticky, no pointer movement, cleared by flush.
        cycle(0, 5'd0, 0, 4'd0, 1, 0, "uf.set");
        check("uf.set", 32'(underflow_o), 32'd1);
        idle("uf.hold");
        check("uf.hold", 32'(underflow_o), 32'd1);
        check("uf.usage", 32'(usage_o), 32'd0);
        cycle(0, 5'd0, 0, 4'd0, 0, 1, "uf.flush");
        check("uf.clear", 32'(underflow_o), 32'd0);

        // Flush beats a same-cycle push and pop.
        cycle(1, 5'd1, 0, 4'd1, 0, 0, "fl.fill");
        cycle(1, 5'd2, 0, 4'd2, 0, 0, "fl.fill");
        cycle(1, 5'd3, 0, 4'd3, 0, 0, "fl.fill");
        cycle(1, 5'd15, 1, 4'd15, 1, 1, "fl.all");
        check("fl.usage", 32'(usage_o),     32'd0);
        check("fl.empty", 32'(empty_o),     32'd1);
        check("fl.valid", 32'(pop_valid_o), 32'd0);
        cycle(1, 5'd20, 1, 4'd4, 0, 0, "fl.after");
        check("fl.after.rd",    32'(pop_rd_o), 32'd20);
        check("fl.after.usage", 32'(usage_o),  32'd1);
        cycle(0, 5'd0, 0, 4'd0, 1, 0, "fl.drain");

        // Asynchronous reset in the middle of a cycle with two entries held.
        cycle(1, 5'd10, 1, 4'd1, 0, 0, "ar.fill");
        cycle(1, 5'd11, 1, 4'd2, 0, 0, "ar.fill");
        #3 rst_ni = 0;
        #1;
        model_q.delete();
        model_uf = 0;
        check("ar.empty", 32'(empty_o),      32'd1);
        check("ar.ready", 32'(push_ready_o), 32'd1);
        check("ar.usage", 32'(usage_o),      32'd0);
        check("ar.valid", 32'(pop_valid_o),  32'd0);
        #1 rst_ni = 1;
        @(posedge clk_i); #1;
        check_model("ar.rel");
        cycle(1, 5'd12, 0, 4'd5, 0, 0, "ar.push");
        check("ar.rd12", 32'(pop_rd_o), 32'd12);
        cycle(0, 5'd0, 0, 4'd0, 1, 0, "ar.pop");

        // Randomized traffic with occasional flushes against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 99) < 60), 5'($urandom), 1'($urandom), 4'($urandom),
                  bit'($urandom_range(0, 99) < 50), bit'($urandom_range(0, 39) == 0), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
